// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with valid/ready on both sides and an illegal-instruction TRAP state.
// Define DECODE_MEXT_EN to decode the M extension (R-type funct7 0x01); otherwise those encodings are illegal.
module decode_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic            MemtoReg,
   output logic            RegWrite,
   output logic            MemWrite,
   output logic            MemRead,
   output logic            Jump,
   output logic            JALR,
   output logic            Branch,
   output logic [4:0]      ALUCode,
   output logic            ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [2:0]      BrFunct3,
   output logic [2:0]      MemSize,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] Imm,
   output logic [XLEN-1:0] offset,
   output logic            illegal
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

   typedef struct packed {
      logic            mem_to_reg;
      logic            reg_write;
      logic            mem_write;
      logic            mem_read;
      logic            jump;
      logic            jalr;
      logic            branch;
      logic [4:0]      alu_code;
      logic            alu_src_a;
      logic [1:0]      alu_src_b;
      logic [2:0]      br_funct3;
      logic [2:0]      mem_size;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] offset;
      logic            illegal;
   } ctrl_t;

   // alt selects sub/sra; the caller only raises it where bit30 is a real opcode bit
   function automatic logic [4:0] alu_rv(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  alu_rv = alt ? 5'd1 : 5'd0;
         3'b001:  alu_rv = 5'd6;
         3'b010:  alu_rv = 5'd9;
         3'b011:  alu_rv = 5'd10;
         3'b100:  alu_rv = 5'd4;
         3'b101:  alu_rv = alt ? 5'd8 : 5'd7;
         3'b110:  alu_rv = 5'd5;
         3'b111:  alu_rv = 5'd3;
         default: alu_rv = 5'd0;
      endcase
   endfunction

   state_t          state_r;
   logic            valid_r;
   ctrl_t           ctrl_r;
   ctrl_t           dec_s;
   logic [XLEN-1:0] pc_r;
   logic [4:0]      rs1_r, rs2_r, rd_r;
   logic            illegal_s;
   logic            accept_s;
   logic [6:0]      opcode_s, funct7_s;
   logic [2:0]      funct3_s;
   logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_j_s, imm_u_s, shamt_s;

   assign opcode_s = in_instr[6:0];
   assign funct3_s = in_instr[14:12];
   assign funct7_s = in_instr[31:25];
   assign imm_i_s  = XLEN'($signed(in_instr[31:20]));
   assign imm_s_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
   assign imm_b_s  = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
   assign imm_j_s  = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
   assign imm_u_s  = XLEN'($signed({in_instr[31:12], 12'h000}));
   assign shamt_s  = XLEN'(in_instr[24:20]);

   assign in_ready = (state_r == RUN) & ~flush & (~valid_r | out_ready);
   assign accept_s = in_valid & in_ready;

   // Combinational decode of the incoming word; an illegal word keeps only the illegal flag.
   always_comb begin
      dec_s     = '0;
      illegal_s = 1'b0;
      case (opcode_s)
         OP_R: begin
            dec_s.reg_write = 1'b1;
            dec_s.alu_code  = alu_rv(funct3_s, in_instr[30]);
            if (funct7_s == 7'h00) begin
               illegal_s = 1'b0;
            end else if (funct7_s == 7'h20) begin
               illegal_s = (funct3_s != 3'b000) && (funct3_s != 3'b101);
`ifdef DECODE_MEXT_EN
            end else if (funct7_s == 7'h01) begin
               dec_s.alu_code = {2'b10, funct3_s};
`endif
            end else begin
               illegal_s = 1'b1;
            end
         end
         OP_I: begin
            dec_s.reg_write = 1'b1;
            dec_s.alu_src_b = 2'b01;
            dec_s.alu_code  = alu_rv(funct3_s, (funct3_s == 3'b101) & in_instr[30]);
            if (funct3_s == 3'b001) begin
               dec_s.imm = shamt_s;
               illegal_s = (funct7_s != 7'h00);
            end else if (funct3_s == 3'b101) begin
               dec_s.imm = shamt_s;
               illegal_s = (funct7_s != 7'h00) && (funct7_s != 7'h20);
            end else begin
               dec_s.imm = imm_i_s;
            end
         end
         OP_LOAD: begin
            dec_s.mem_to_reg = 1'b1;
            dec_s.mem_read   = 1'b1;
            dec_s.reg_write  = 1'b1;
            dec_s.alu_src_b  = 2'b01;
            dec_s.imm        = imm_i_s;
            dec_s.mem_size   = funct3_s;
            illegal_s = (funct3_s == 3'b011) || (funct3_s == 3'b110) || (funct3_s == 3'b111);
         end
         OP_STORE: begin
            dec_s.mem_write = 1'b1;
            dec_s.alu_src_b = 2'b01;
            dec_s.imm       = imm_s_s;
            dec_s.mem_size  = funct3_s;
            illegal_s = (funct3_s > 3'b010);
         end
         OP_BRANCH: begin
            dec_s.branch    = 1'b1;
            dec_s.alu_code  = 5'd1;
            dec_s.br_funct3 = funct3_s;
            dec_s.offset    = imm_b_s;
            illegal_s = (funct3_s == 3'b010) || (funct3_s == 3'b011);
         end
         OP_JAL: begin
            dec_s.jump      = 1'b1;
            dec_s.reg_write = 1'b1;
            dec_s.alu_src_a = 1'b1;
            dec_s.alu_src_b = 2'b10;
            dec_s.offset    = imm_j_s;
         end
         OP_JALR: begin
            dec_s.jump      = 1'b1;
            dec_s.jalr      = 1'b1;
            dec_s.reg_write = 1'b1;
            dec_s.alu_src_a = 1'b1;
            dec_s.alu_src_b = 2'b10;
            dec_s.offset    = imm_i_s;
            illegal_s = (funct3_s != 3'b000);
         end
         OP_LUI: begin
            dec_s.reg_write = 1'b1;
            dec_s.alu_code  = 5'd2;
            dec_s.alu_src_b = 2'b01;
            dec_s.imm       = imm_u_s;
         end
         OP_AUIPC: begin
            dec_s.reg_write = 1'b1;
            dec_s.alu_src_a = 1'b1;
            dec_s.alu_src_b = 2'b01;
            dec_s.imm       = imm_u_s;
         end
         default: begin
            illegal_s = 1'b1;
         end
      endcase
      if (illegal_s || (in_instr[1:0] != 2'b11)) begin
         dec_s         = '0;
         dec_s.illegal = 1'b1;
      end else begin
         dec_s.illegal = 1'b0;
      end
   end

   // Stage register and RUN/TRAP state; flush outranks accept and drain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= RUN;
         valid_r <= 1'b0;
         ctrl_r  <= '0;
         pc_r    <= '0;
         rs1_r   <= 5'd0;
         rs2_r   <= 5'd0;
         rd_r    <= 5'd0;
      end else if (flush) begin
         state_r <= RUN;
         valid_r <= 1'b0;
      end else if (accept_s) begin
         valid_r <= 1'b1;
         ctrl_r  <= dec_s;
         pc_r    <= in_pc;
         rs1_r   <= in_instr[19:15];
         rs2_r   <= in_instr[24:20];
         rd_r    <= in_instr[11:7];
         state_r <= dec_s.illegal ? TRAP : RUN;
      end else if (out_ready) begin
         valid_r <= 1'b0;
      end
   end

   assign out_valid = valid_r;
   assign out_pc    = pc_r;
   assign MemtoReg  = ctrl_r.mem_to_reg;
   assign RegWrite  = ctrl_r.reg_write;
   assign MemWrite  = ctrl_r.mem_write;
   assign MemRead   = ctrl_r.mem_read;
   assign Jump      = ctrl_r.jump;
   assign JALR      = ctrl_r.jalr;
   assign Branch    = ctrl_r.branch;
   assign ALUCode   = ctrl_r.alu_code;
   assign ALUSrcA   = ctrl_r.alu_src_a;
   assign ALUSrcB   = ctrl_r.alu_src_b;
   assign BrFunct3  = ctrl_r.br_funct3;
   assign MemSize   = ctrl_r.mem_size;
   assign rs1       = rs1_r;
   assign rs2       = rs2_r;
   assign rd        = rd_r;
   assign Imm       = ctrl_r.imm;
   assign offset    = ctrl_r.offset;
   assign illegal   = ctrl_r.illegal;

endmodule
